// File: rtl/sar_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sar_seq_ctrl_if
// Purpose  : Result hand-off bundle between the SAR sequencer and its consumer.
//            The sequencer (master) publishes the conversion word, its channel,
//            a valid flag and a sticky overrun flag. The consumer (slave) returns
//            result_ready to accept the word.
// Signals  : result       [N_BITS]  last conversion, MSB = first decision
//            result_ch    [SEL_W]   channel the result belongs to
//            result_valid           result available
//            result_ready           consumer accepts result
//            overrun                an unconsumed result was overwritten
// Revision : 1.0 - initial release
// ============================================================================
interface sar_seq_ctrl_if #(
  parameter int N_CH   = 16,
  parameter int N_BITS = 16,
  parameter int SEL_W  = $clog2(N_CH)
);
  logic [N_BITS-1:0] result;
  logic [SEL_W-1:0]  result_ch;
  logic              result_valid;
  logic              result_ready;
  logic              overrun;

  modport master (
    output result,
    output result_ch,
    output result_valid,
    output overrun,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_ch,
    input  result_valid,
    input  overrun,
    output result_ready
  );
endinterface
`default_nettype wire

// File: rtl/sar_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sar_seq_ctrl
// Purpose  : SAR ADC sequencer. Generates the INIT/SAMP/CMP/LOGIC phase strobes
//            with programmable lengths, drives the comparator mux select,
//            shifts the selected channel's decisions into an N_BITS word and
//            publishes it through a valid/ready hand-off. Single-shot,
//            continuous and channel-scan operation.
// Ports    : clk, rst_b                 clock, async active-low reset
//            start                      conversion request (ignored while busy)
//            cont_mode, scan_mode       auto-restart / auto-advance channel
//            ch_sel                     starting channel
//            t_init/t_samp/t_cmp/t_logic phase length minus one, in cycles
//            comp_in                    per-channel comparator outputs
//            seq_init..seq_logic        registered phase strobes
//            mux_sel                    active channel
//            busy                       high from INIT until DONE is exited
//            res_if                     result hand-off (master side)
// Revision : 1.0 - initial release
// ============================================================================
module sar_seq_ctrl #(
  parameter int N_CH   = 16,
  parameter int N_BITS = 16,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int CNT_W  = 8
) (
  input  wire              clk,
  input  wire              rst_b,
  input  wire              start,
  input  wire              cont_mode,
  input  wire              scan_mode,
  input  wire [SEL_W-1:0]  ch_sel,
  input  wire [CNT_W-1:0]  t_init,
  input  wire [CNT_W-1:0]  t_samp,
  input  wire [CNT_W-1:0]  t_cmp,
  input  wire [CNT_W-1:0]  t_logic,
  input  wire [N_CH-1:0]   comp_in,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_cmp,
  output logic             seq_logic,
  output logic [SEL_W-1:0] mux_sel,
  output logic             busy,
  sar_seq_ctrl_if.master   res_if
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_SAMP  = 3'd2,
    S_CMP   = 3'd3,
    S_LOGIC = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int                 c_bit_w    = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(N_BITS - 1);
  localparam logic [SEL_W-1:0]   c_last_ch  = SEL_W'(N_CH - 1);

  // Strobe vector order: {logic, cmp, samp, init}
  localparam logic [3:0] c_strb_none  = 4'b0000;
  localparam logic [3:0] c_strb_init  = 4'b0001;
  localparam logic [3:0] c_strb_samp  = 4'b0010;
  localparam logic [3:0] c_strb_cmp   = 4'b0100;
  localparam logic [3:0] c_strb_logic = 4'b1000;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_t_init;
  logic [CNT_W-1:0]   r_t_samp;
  logic [CNT_W-1:0]   r_t_cmp;
  logic [CNT_W-1:0]   r_t_logic;
  logic [c_bit_w-1:0] r_bit;
  logic [SEL_W-1:0]   r_ch;
  logic [N_BITS-1:0]  r_cap;
  logic [N_BITS-1:0]  r_result;
  logic [SEL_W-1:0]   r_result_ch;
  logic [3:0]         r_strb;
  logic               r_busy;
  logic               r_valid;
  logic               r_overrun;

  logic [CNT_W-1:0]   w_len;
  logic               w_phase_end;
  logic [SEL_W-1:0]   w_start_ch;
  logic [SEL_W-1:0]   w_next_ch;

  // Length of the phase currently being timed (latched copies only, so a
  // register write mid-conversion cannot stretch or cut a phase).
  always_comb begin
    w_len = '0;
    case (r_state)
      S_INIT:  w_len = r_t_init;
      S_SAMP:  w_len = r_t_samp;
      S_CMP:   w_len = r_t_cmp;
      S_LOGIC: w_len = r_t_logic;
      default: w_len = '0;
    endcase
  end

  assign w_phase_end = (r_cnt == w_len);
  // Out-of-range start channel falls back to channel 0.
  assign w_start_ch  = (32'(ch_sel) >= N_CH) ? '0 : ch_sel;
  assign w_next_ch   = (r_ch == c_last_ch) ? '0 : r_ch + 1'b1;

  // Strobes and busy are registered alongside every state change so that
  // each strobe exactly covers its state.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_t_init    <= '0;
      r_t_samp    <= '0;
      r_t_cmp     <= '0;
      r_t_logic   <= '0;
      r_bit       <= '0;
      r_ch        <= '0;
      r_cap       <= '0;
      r_result    <= '0;
      r_result_ch <= '0;
      r_strb      <= c_strb_none;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      // Consumer acceptance; a DONE load below takes precedence.
      if (res_if.result_ready) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_t_init  <= t_init;
            r_t_samp  <= t_samp;
            r_t_cmp   <= t_cmp;
            r_t_logic <= t_logic;
            r_ch      <= w_start_ch;
            r_overrun <= 1'b0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_state   <= S_INIT;
            r_strb    <= c_strb_init;
            r_busy    <= 1'b1;
          end
        end

        S_INIT: begin
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_state <= S_SAMP;
            r_strb  <= c_strb_samp;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_SAMP: begin
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_state <= S_CMP;
            r_strb  <= c_strb_cmp;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_CMP: begin
          if (w_phase_end) begin
            r_cnt   <= '0;
            r_state <= S_LOGIC;
            r_strb  <= c_strb_logic;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_LOGIC: begin
          // One decision per LOGIC state, taken on its first cycle; the
          // truncating cast turns the concatenation into a left shift.
          if (r_cnt == '0) begin
            r_cap <= N_BITS'({r_cap, comp_in[r_ch]});
          end
          if (w_phase_end) begin
            r_cnt <= '0;
            r_bit <= r_bit + 1'b1;
            if (r_bit == c_last_bit) begin
              r_state <= S_DONE;
              r_strb  <= c_strb_none;
            end else begin
              r_state <= S_CMP;
              r_strb  <= c_strb_cmp;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_result    <= r_cap;
          r_result_ch <= r_ch;
          r_valid     <= 1'b1;
          if (r_valid && !res_if.result_ready) begin
            r_overrun <= 1'b1;
          end
          if (scan_mode) begin
            r_ch <= w_next_ch;
          end
          r_cnt <= '0;
          r_bit <= '0;
          if (cont_mode) begin
            r_t_init  <= t_init;
            r_t_samp  <= t_samp;
            r_t_cmp   <= t_cmp;
            r_t_logic <= t_logic;
            r_state   <= S_INIT;
            r_strb    <= c_strb_init;
          end else begin
            r_state <= S_IDLE;
            r_strb  <= c_strb_none;
            r_busy  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_strb  <= c_strb_none;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign seq_init            = r_strb[0];
  assign seq_samp            = r_strb[1];
  assign seq_cmp             = r_strb[2];
  assign seq_logic           = r_strb[3];
  assign mux_sel             = r_ch;
  assign busy                = r_busy;
  assign res_if.result       = r_result;
  assign res_if.result_ch    = r_result_ch;
  assign res_if.result_valid = r_valid;
  assign res_if.overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sar_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_seq_ctrl
// Purpose  : Self-checking bench for sar_seq_ctrl. A schedule-based reference
//            model expands each conversion into its per-cycle phase list and
//            is compared against the DUT every cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_seq_ctrl;
  localparam int N_CH   = 16;
  localparam int N_BITS = 16;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 8;

  // Phase codes used by the model schedule
  localparam int P_IDLE = 0, P_INIT = 1, P_SAMP = 2, P_CMP = 3;
  localparam int P_LOG = 4, P_LOG1 = 5, P_DONE = 6;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             start;
  logic             cont_mode;
  logic             scan_mode;
  logic [SEL_W-1:0] ch_sel;
  logic [CNT_W-1:0] t_init, t_samp, t_cmp, t_logic;
  logic [N_CH-1:0]  comp_in;
  logic             seq_init, seq_samp, seq_cmp, seq_logic;
  logic [SEL_W-1:0] mux_sel;
  logic             busy;

  always #5 clk = ~clk;

  sar_seq_ctrl_if #(.N_CH(N_CH), .N_BITS(N_BITS), .SEL_W(SEL_W)) rif ();

  sar_seq_ctrl #(.N_CH(N_CH), .N_BITS(N_BITS), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .cont_mode(cont_mode),
    .scan_mode(scan_mode),
    .ch_sel   (ch_sel),
    .t_init   (t_init),
    .t_samp   (t_samp),
    .t_cmp    (t_cmp),
    .t_logic  (t_logic),
    .comp_in  (comp_in),
    .seq_init (seq_init),
    .seq_samp (seq_samp),
    .seq_cmp  (seq_cmp),
    .seq_logic(seq_logic),
    .mux_sel  (mux_sel),
    .busy     (busy),
    .res_if   (rif)
  );

  int total = 0;
  int bad   = 0;

  // Comparator stimulus: at each new LOGIC state the next pattern bit is
  // driven onto every channel in mask.
  logic [N_BITS-1:0] pat  = '0;
  logic [N_CH-1:0]   mask = '1;
  logic              cur_bit = 1'b1;
  logic              prev_logic = 1'b0;
  int                k = 0;

  // Reference model
  int                q[$];
  int                m_ph;
  logic [N_BITS-1:0] m_cap, m_res;
  int                m_ch, m_rch;
  logic              m_valid, m_ovr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task model_reset();
    q.delete();
    m_ph = P_IDLE; m_cap = '0; m_res = '0;
    m_ch = 0; m_rch = 0; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  // Expand one conversion into the ordered list of cycles it occupies.
  task build_q();
    q.delete();
    repeat (int'(t_init) + 1) q.push_back(P_INIT);
    repeat (int'(t_samp) + 1) q.push_back(P_SAMP);
    for (int b = 0; b < N_BITS; b++) begin
      repeat (int'(t_cmp) + 1) q.push_back(P_CMP);
      q.push_back(P_LOG1);
      repeat (int'(t_logic)) q.push_back(P_LOG);
    end
    q.push_back(P_DONE);
  endtask

  // Effect of the cycle that ends at this rising edge.
  task model_step();
    logic rdy;
    rdy = rif.result_ready;
    if (m_ph == P_DONE) begin
      if (m_valid && !rdy) m_ovr = 1'b1;
      m_res   = m_cap;
      m_rch   = m_ch;
      m_valid = 1'b1;
      if (scan_mode) m_ch = (m_ch + 1) % N_CH;
      if (cont_mode) build_q();
    end else begin
      if (rdy) m_valid = 1'b0;
      if (m_ph == P_LOG1) m_cap = (m_cap << 1) | N_BITS'(comp_in[m_ch]);
      if (m_ph == P_IDLE && start) begin
        m_ovr = 1'b0;
        m_ch  = (int'(ch_sel) < N_CH) ? int'(ch_sel) : 0;
        build_q();
      end
    end
    m_ph = (q.size() > 0) ? q.pop_front() : P_IDLE;
  endtask

  task compare_all();
    check("seq_init", seq_init, m_ph == P_INIT);
    check("seq_samp", seq_samp, m_ph == P_SAMP);
    check("seq_cmp", seq_cmp, m_ph == P_CMP);
    check("seq_logic", seq_logic, (m_ph == P_LOG) || (m_ph == P_LOG1));
    check("busy", busy, m_ph != P_IDLE);
    check("mux_sel", mux_sel, m_ch);
    check("result_valid", rif.result_valid, m_valid);
    check("result", rif.result, m_res);
    check("result_ch", rif.result_ch, m_rch);
    check("overrun", rif.overrun, m_ovr);
  endtask

  task tick();
    @(posedge clk);
    if (rst_b) model_step();
    else model_reset();
    @(negedge clk);
    if (seq_init) k = 0;
    if (seq_logic && !prev_logic) begin
      cur_bit = (k < N_BITS) ? pat[N_BITS-1-k] : 1'b0;
      k++;
    end
    prev_logic = seq_logic;
    comp_in = cur_bit ? mask : '0;
    compare_all();
  endtask

  task automatic run_conv(output int lat, output int ni, output int ns, output int nc, output int nl);
    lat = 0; ni = 0; ns = 0; nc = 0; nl = 0;
    start = 1'b1;
    do begin
      tick();
      start = 1'b0;
      lat++;
      ni += int'(seq_init); ns += int'(seq_samp);
      nc += int'(seq_cmp);  nl += int'(seq_logic);
    end while (!rif.result_valid && lat < 400);
  endtask

  task automatic wait_done_cycle(input string name);
    int g;
    g = 0;
    while (!(busy && !(seq_init | seq_samp | seq_cmp | seq_logic)) && g < 400) begin
      tick(); g++;
    end
    check(name, g < 400, 1'b1);
  endtask

  initial begin
    int lat, ni, ns, nc, nl, nres, g, rises;
    logic pc;
    int chs[4];

    // ---------------- reset with start held and all comparators high
    rst_b = 1'b0; start = 1'b1; cont_mode = 1'b0; scan_mode = 1'b0;
    ch_sel = '0; t_init = '0; t_samp = '0; t_cmp = '0; t_logic = '0;
    comp_in = '1; rif.result_ready = 1'b0;
    mask = '1; pat = '1;
    model_reset();
    repeat (4) tick();
    check("rst_busy", busy, 0);
    check("rst_strobes", {seq_init, seq_samp, seq_cmp, seq_logic}, 0);
    check("rst_valid", rif.result_valid, 0);
    check("rst_mux_sel", mux_sel, 0);
    start = 1'b0;
    rst_b = 1'b1;
    repeat (3) tick();
    check("idle_after_rst", busy, 0);

    // ---------------- single shot, channel 5, alternating decisions
    ch_sel = 4'd5; mask = 16'h0020; pat = 16'hAAAA;
    run_conv(lat, ni, ns, nc, nl);
    check("t1_latency", lat, 36);
    check("t1_result", rif.result, 16'hAAAA);
    check("t1_result_ch", rif.result_ch, 5);
    check("t1_init_cycles", ni, 1);
    check("t1_samp_cycles", ns, 1);
    check("t1_cmp_cycles", nc, 16);
    check("t1_logic_cycles", nl, 16);
    check("t1_idle", busy, 0);
    rif.result_ready = 1'b1;
    tick();
    check("t1_accept", rif.result_valid, 0);

    // ---------------- programmed phase lengths
    t_init = 8'd3; t_samp = 8'd2; t_cmp = 8'd1; t_logic = 8'd0;
    pat = 16'hC35A;
    run_conv(lat, ni, ns, nc, nl);
    check("t2_latency", lat, 57);
    check("t2_init_cycles", ni, 4);
    check("t2_samp_cycles", ns, 3);
    check("t2_cmp_cycles", nc, 32);
    check("t2_logic_cycles", nl, 16);
    check("t2_result", rif.result, 16'hC35A);
    tick();

    // ---------------- scan + continuous from channel 14
    t_init = '0; t_samp = '0; t_cmp = '0; t_logic = '0;
    ch_sel = 4'd14; cont_mode = 1'b1; scan_mode = 1'b1; mask = '1; pat = 16'h0F0F;
    start = 1'b1;
    nres = 0; g = 0;
    while (nres < 4 && g < 1000) begin
      tick(); start = 1'b0; g++;
      if (rif.result_valid) begin
        chs[nres] = int'(rif.result_ch);
        nres++;
        if (nres == 3) begin
          tick(); tick();
          cont_mode = 1'b0;
        end
      end
    end
    check("t3_results", nres, 4);
    check("t3_ch0", chs[0], 14);
    check("t3_ch1", chs[1], 15);
    check("t3_ch2", chs[2], 0);
    check("t3_ch3", chs[3], 1);
    check("t3_idle", busy, 0);
    tick();
    check("t3_still_idle", busy, 0);

    // ---------------- overrun in continuous mode
    scan_mode = 1'b0; cont_mode = 1'b1; ch_sel = 4'd3;
    rif.result_ready = 1'b0; pat = 16'hF00F; mask = 16'h0008;
    run_conv(lat, ni, ns, nc, nl);
    check("t4_first_valid", rif.result_valid, 1);
    check("t4_no_ovr_yet", rif.overrun, 0);
    pat = 16'h1234;
    g = 0;
    while (!rif.overrun && g < 400) begin tick(); g++; end
    check("t4_overrun", rif.overrun, 1);
    check("t4_valid_kept", rif.result_valid, 1);
    check("t4_new_data", rif.result, 16'h1234);
    cont_mode = 1'b0;
    g = 0;
    while (busy && g < 400) begin tick(); g++; end
    check("t4_stopped", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_ovr_cleared", rif.overrun, 0);
    pat = 16'h5A0F;
    wait_done_cycle("t4_done_seen");
    rif.result_ready = 1'b1;
    tick();
    check("t4_ready_no_ovr", rif.overrun, 0);
    check("t4_ready_valid", rif.result_valid, 1);
    check("t4_ready_data", rif.result, 16'h5A0F);
    rif.result_ready = 1'b0;
    tick();

    // ---------------- ignored start while busy, then reset during 3rd CMP
    ch_sel = 4'd2; t_init = 8'd2; t_cmp = 8'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ch_sel = 4'd15; start = 1'b1;
    tick();
    start = 1'b0; ch_sel = 4'd2;
    check("t5_start_ignored", mux_sel, 2);
    rises = 0; g = 0; pc = 1'b0;
    while (rises < 3 && g < 300) begin
      tick(); g++;
      if (seq_cmp && !pc) rises++;
      pc = seq_cmp;
    end
    check("t5_cmp3_reached", rises, 3);
    tick();
    check("t5_in_cmp", seq_cmp, 1);
    #1 rst_b = 1'b0;
    #1;
    check("t5_rst_cmp", seq_cmp, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_valid", rif.result_valid, 0);
    check("t5_rst_mux", mux_sel, 0);
    model_reset();
    #1 rst_b = 1'b1;
    repeat (60) tick();
    check("t5_no_publish", rif.result_valid, 0);
    check("t5_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
